// File: rtl/digit_serial_add_sub_if.sv
// Purpose: operand/result bundle for the digit-serial adder/subtractor.
//   Operand side : vld, a, b, sub, last       (driven by the master)
//   Result side  : sum_vld, sum, sum_last, carry_out, overflow, len_err
//                  (driven by the slave, i.e. the arithmetic block)
// The DIGIT_W parameter must match the DIGIT_W of the block it connects to.
interface digit_serial_add_sub_if #(
  parameter int DIGIT_W = 4
);
  logic               vld;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               sub;
  logic               last;

  logic               sum_vld;
  logic [DIGIT_W-1:0] sum;
  logic               sum_last;
  logic               carry_out;
  logic               overflow;
  logic               len_err;

  modport master (
    output vld, a, b, sub, last,
    input  sum_vld, sum, sum_last, carry_out, overflow, len_err
  );

  modport slave (
    input  vld, a, b, sub, last,
    output sum_vld, sum, sum_last, carry_out, overflow, len_err
  );
endinterface

// File: rtl/digit_serial_add_sub.sv
// Purpose: digit-serial two's-complement adder/subtractor. Operands arrive
//   LSB-first, DIGIT_W bits per valid beat; each beat yields one registered
//   result digit one cycle later. The final digit also carries carry-out,
//   signed overflow and a length error flag (operand cut at MAX_BEATS).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of digit_serial_add_sub_if (operand in, result out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for first beat of an operand; mode and cin come from sub
// RUN   | mid-operand; latched mode and stored carry are used, sub ignored
module digit_serial_add_sub #(
  parameter int DIGIT_W   = 4,
  parameter int MAX_BEATS = 16
) (
  input logic                   clk,
  input logic                   rst,
  digit_serial_add_sub_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               carry;
  logic               mode;
  logic [CNT_W-1:0]   beat_cnt;

  logic               mode_eff;
  logic               cin;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   full;
  logic               c_msb_in;
  logic               op_end;

  logic               sum_vld_q;
  logic [DIGIT_W-1:0] sum_q;
  logic               sum_last_q;
  logic               carry_out_q;
  logic               overflow_q;
  logic               len_err_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.vld && !op_end) state_nxt = RUN;
      RUN:     if (op_end)             state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // per-beat arithmetic and end-of-operand decode
  always_comb begin
    mode_eff = (state == IDLE) ? bus.sub : mode;
    cin      = (state == IDLE) ? bus.sub : carry;
    b_eff    = bus.b ^ {DIGIT_W{mode_eff}};
    full     = {1'b0, bus.a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    // carry into the digit MSB recovered from the MSB sum bit; works for DIGIT_W=1
    c_msb_in = bus.a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ full[DIGIT_W-1];
    op_end   = bus.vld && (bus.last || (beat_cnt == CNT_W'(MAX_BEATS - 1)));
  end

  // operand context: carry, beat count, latched mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry    <= 1'b0;
      beat_cnt <= '0;
      mode     <= 1'b0;
    end else if (bus.vld) begin
      if (state == IDLE) mode <= bus.sub;
      if (op_end) begin
        carry    <= 1'b0;
        beat_cnt <= '0;
      end else begin
        carry    <= full[DIGIT_W];
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // registered result; sum holds across idle cycles, flags pulse only on the last digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_vld_q   <= 1'b0;
      sum_q       <= '0;
      sum_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      sum_vld_q   <= bus.vld;
      if (bus.vld) sum_q <= full[DIGIT_W-1:0];
      sum_last_q  <= op_end;
      carry_out_q <= op_end & full[DIGIT_W];
      overflow_q  <= op_end & (c_msb_in ^ full[DIGIT_W]);
      len_err_q   <= op_end & ~bus.last;
    end
  end

  assign bus.sum_vld   = sum_vld_q;
  assign bus.sum       = sum_q;
  assign bus.sum_last  = sum_last_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.len_err   = len_err_q;
endmodule

// File: tb/tb_digit_serial_add_sub.sv
module tb_digit_serial_add_sub;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  digit_serial_add_sub_if #(.DIGIT_W(4)) if0 ();
  digit_serial_add_sub_if #(.DIGIT_W(4)) if1 ();
  digit_serial_add_sub_if #(.DIGIT_W(1)) if2 ();

  digit_serial_add_sub #(.DIGIT_W(4), .MAX_BEATS(16)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  digit_serial_add_sub #(.DIGIT_W(4), .MAX_BEATS(4))  u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  digit_serial_add_sub #(.DIGIT_W(1), .MAX_BEATS(16)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // {sum_vld, sum, sum_last, carry_out, overflow, len_err}
  logic [8:0] obs0, obs1;
  logic [5:0] obs2;
  assign obs0 = {if0.sum_vld, if0.sum, if0.sum_last, if0.carry_out, if0.overflow, if0.len_err};
  assign obs1 = {if1.sum_vld, if1.sum, if1.sum_last, if1.carry_out, if1.overflow, if1.len_err};
  assign obs2 = {if2.sum_vld, if2.sum, if2.sum_last, if2.carry_out, if2.overflow, if2.len_err};

  function automatic logic [8:0] pk4(input logic v, input logic [3:0] s, input logic l,
                                     input logic c, input logic o, input logic e);
    return {v, s, l, c, o, e};
  endfunction

  function automatic logic [5:0] pk1(input logic v, input logic s, input logic l,
                                     input logic c, input logic o, input logic e);
    return {v, s, l, c, o, e};
  endfunction

  task automatic drive0(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic l);
    @(negedge clk);
    if0.vld = v; if0.a = a; if0.b = b; if0.sub = s; if0.last = l;
    @(posedge clk); #1;
  endtask

  task automatic drive1(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic l);
    @(negedge clk);
    if1.vld = v; if1.a = a; if1.b = b; if1.sub = s; if1.last = l;
    @(posedge clk); #1;
  endtask

  task automatic drive2(input logic v, input logic a, input logic b,
                        input logic s, input logic l);
    @(negedge clk);
    if2.vld = v; if2.a = a; if2.b = b; if2.sub = s; if2.last = l;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.vld = 0; if0.a = 0; if0.b = 0; if0.sub = 0; if0.last = 0;
    if1.vld = 0; if1.a = 0; if1.b = 0; if1.sub = 0; if1.last = 0;
    if2.vld = 0; if2.a = 0; if2.b = 0; if2.sub = 0; if2.last = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs0 !== 9'h0) begin errors++; $display("FAIL reset_u0 obs=%h exp=%h", obs0, 9'h0); end
    checks++;
    if (obs1 !== 9'h0) begin errors++; $display("FAIL reset_u1 obs=%h exp=%h", obs1, 9'h0); end
    checks++;
    if (obs2 !== 6'h0) begin errors++; $display("FAIL reset_u2 obs=%h exp=%h", obs2, 6'h0); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add(input string tag);
    logic [8:0] exp;
    drive0(1, 4'hA, 4'h7, 0, 0);
    exp = pk4(1, 4'h1, 0, 0, 0, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL %s_d0 obs=%h exp=%h", tag, obs0, exp); end
    drive0(1, 4'h3, 4'h1, 0, 1);
    exp = pk4(1, 4'h5, 1, 0, 0, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL %s_d1 obs=%h exp=%h", tag, obs0, exp); end
    drive0(0, 4'h0, 4'h0, 0, 1);
    exp = pk4(0, 4'h5, 0, 0, 0, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL %s_idle obs=%h exp=%h", tag, obs0, exp); end
  endtask

  task automatic test_sub();
    logic [8:0] exp;
    drive0(1, 4'hA, 4'h7, 1, 0);
    exp = pk4(1, 4'h3, 0, 0, 0, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL sub_d0 obs=%h exp=%h", obs0, exp); end
    // sub dropped mid-operand must not change the mode
    drive0(1, 4'h3, 4'h1, 0, 1);
    exp = pk4(1, 4'h2, 1, 1, 0, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL sub_d1 obs=%h exp=%h", obs0, exp); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    drive0(1, 4'h7, 4'h1, 0, 1);
    exp = pk4(1, 4'h8, 1, 0, 1, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL ovf_add obs=%h exp=%h", obs0, exp); end
    drive0(1, 4'h8, 4'h1, 1, 1);
    exp = pk4(1, 4'h7, 1, 1, 1, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL ovf_sub obs=%h exp=%h", obs0, exp); end
    drive0(0, 4'h0, 4'h0, 0, 0);
  endtask

  task automatic test_gaps();
    logic [8:0] exp;
    drive0(1, 4'hA, 4'h7, 0, 0);
    exp = pk4(1, 4'h1, 0, 0, 0, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL gap_d0 obs=%h exp=%h", obs0, exp); end
    for (int i = 0; i < 3; i++) begin
      // last toggled during the gap must be ignored
      drive0(0, 4'hF, 4'hF, 1, 1);
      exp = pk4(0, 4'h1, 0, 0, 0, 0);
      checks++;
      if (obs0 !== exp) begin errors++; $display("FAIL gap_idle%0d obs=%h exp=%h", i, obs0, exp); end
    end
    drive0(1, 4'h3, 4'h1, 0, 1);
    exp = pk4(1, 4'h5, 1, 0, 0, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL gap_d1 obs=%h exp=%h", obs0, exp); end
    drive0(0, 4'h0, 4'h0, 0, 0);
  endtask

  task automatic test_reset_abort();
    logic [8:0] exp;
    drive0(1, 4'hA, 4'h7, 0, 0);
    exp = pk4(1, 4'h1, 0, 0, 0, 0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL abort_d0 obs=%h exp=%h", obs0, exp); end
    @(negedge clk);
    if0.vld = 0;
    rst = 1'b1;
    #1;
    checks++;
    if (obs0 !== 9'h0) begin errors++; $display("FAIL abort_async obs=%h exp=%h", obs0, 9'h0); end
    @(posedge clk); #1;
    checks++;
    if (obs0 !== 9'h0) begin errors++; $display("FAIL abort_hold obs=%h exp=%h", obs0, 9'h0); end
    @(negedge clk);
    rst = 1'b0;
    test_add("replay");
  endtask

  task automatic test_length();
    logic [8:0] exp;
    drive1(1, 4'hF, 4'h1, 0, 0);
    exp = pk4(1, 4'h0, 0, 0, 0, 0);
    checks++;
    if (obs1 !== exp) begin errors++; $display("FAIL len_d0 obs=%h exp=%h", obs1, exp); end
    drive1(1, 4'h0, 4'h0, 0, 0);
    exp = pk4(1, 4'h1, 0, 0, 0, 0);
    checks++;
    if (obs1 !== exp) begin errors++; $display("FAIL len_d1 obs=%h exp=%h", obs1, exp); end
    drive1(1, 4'h0, 4'h0, 0, 0);
    exp = pk4(1, 4'h0, 0, 0, 0, 0);
    checks++;
    if (obs1 !== exp) begin errors++; $display("FAIL len_d2 obs=%h exp=%h", obs1, exp); end
    drive1(1, 4'h0, 4'h0, 0, 0);
    exp = pk4(1, 4'h0, 1, 0, 0, 1);
    checks++;
    if (obs1 !== exp) begin errors++; $display("FAIL len_d3 obs=%h exp=%h", obs1, exp); end
    drive1(1, 4'h5, 4'h5, 0, 1);
    exp = pk4(1, 4'hA, 1, 0, 1, 0);
    checks++;
    if (obs1 !== exp) begin errors++; $display("FAIL len_next obs=%h exp=%h", obs1, exp); end
    drive1(0, 4'h0, 4'h0, 0, 0);
  endtask

  task automatic test_digit1();
    logic [5:0] exp;
    drive2(1, 1'b1, 1'b1, 0, 0);
    exp = pk1(1, 1'b0, 0, 0, 0, 0);
    checks++;
    if (obs2 !== exp) begin errors++; $display("FAIL w1_d0 obs=%h exp=%h", obs2, exp); end
    drive2(1, 1'b0, 1'b0, 0, 1);
    exp = pk1(1, 1'b1, 1, 0, 1, 0);
    checks++;
    if (obs2 !== exp) begin errors++; $display("FAIL w1_d1 obs=%h exp=%h", obs2, exp); end
    drive2(0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add("add");
    test_sub();
    test_back_to_back();
    test_gaps();
    test_reset_abort();
    test_length();
    test_digit1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
